// File: rtl/if_fetch_buf_pkg.sv
// Shared constants and types for the instruction-fetch front end.
package if_fetch_buf_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;
  localparam int IF_STATE_W  = 2;

  localparam logic [INST_ADDR_W-1:0] ZERO_WORD    = 32'h0000_0000;
  localparam logic                   CHIP_ENABLE  = 1'b1;
  localparam logic                   CHIP_DISABLE = 1'b0;

  typedef enum logic [IF_STATE_W-1:0] {
    IF_IDLE = 2'd0,
    IF_RUN  = 2'd1,
    IF_FULL = 2'd2
  } if_state_e;

  // Force an address onto a word boundary; the ROM is word-addressed.
  function automatic logic [INST_ADDR_W-1:0] word_align(input logic [INST_ADDR_W-1:0] addr);
    return {addr[INST_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_buf_fifo.sv
// Small {pc, inst} FIFO: push/pop/clear with a combinational head view.
module fetch_fifo
  import if_fetch_buf_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [INST_ADDR_W-1:0] push_pc,
  input  logic [INST_W-1:0]      push_inst,
  input  logic                   pop,
  input  logic                   clear,
  output logic [PTR_W:0]         count,
  output logic                   head_valid,
  output logic [INST_ADDR_W-1:0] head_pc,
  output logic [INST_W-1:0]      head_inst
);

  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

  logic [INST_ADDR_W+INST_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]              wr_ptr;
  logic [PTR_W-1:0]              rd_ptr;
  logic                          do_push;
  logic                          do_pop;

  assign do_push = push && !clear && (count != DEPTH_CNT);
  assign do_pop  = pop && !clear && (count != '0);

  // Entry storage needs no reset; the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= {push_pc, push_inst};
    end
  end

  // Pointers and occupancy; clear wins over any simultaneous push or pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

  // Present the head entry, or zeros when nothing is buffered.
  always_comb begin
    head_valid = (count != '0);
    head_pc    = ZERO_WORD;
    head_inst  = ZERO_WORD;
    if (head_valid) begin
      {head_pc, head_inst} = mem[rd_ptr];
    end
  end

endmodule

// File: rtl/if_fetch_buf.sv
// Instruction-fetch front end: PC register, fetch state machine, redirect priority.
module if_fetch_buf
  import if_fetch_buf_pkg::*;
#(
  parameter logic [INST_ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int                     DEPTH    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   rom_ce_o,
  output logic [INST_ADDR_W-1:0] rom_addr_o,
  input  logic [INST_W-1:0]      rom_inst_i,
  input  logic                   branch_flag_i,
  input  logic [INST_ADDR_W-1:0] branch_target_i,
  input  logic                   flush_i,
  input  logic [INST_ADDR_W-1:0] new_pc_i,
  output logic                   id_valid_o,
  input  logic                   id_ready_i,
  output logic [INST_ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0]      id_inst_o
);

  localparam int             PTR_W     = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

  if_state_e              state_q;
  if_state_e              state_d;
  logic [INST_ADDR_W-1:0] pc_q;
  logic [PTR_W:0]         fifo_count;
  logic [PTR_W:0]         count_next;
  logic                   redirect;
  logic [INST_ADDR_W-1:0] redirect_target;
  logic                   fetch;
  logic                   pop;

  // Flush outranks branch; the fetch enable looks only at registered state.
  always_comb begin
    redirect        = flush_i || branch_flag_i;
    redirect_target = flush_i ? new_pc_i : branch_target_i;
    rom_ce_o        = ((state_q == IF_RUN) && (fifo_count < DEPTH_CNT)) ? CHIP_ENABLE : CHIP_DISABLE;
    fetch           = rom_ce_o && !redirect;
    pop             = id_valid_o && id_ready_i;
    count_next      = fifo_count + (PTR_W+1)'(fetch) - (PTR_W+1)'(pop);
  end

  assign rom_addr_o = pc_q;

  // Next-state logic: one dead IDLE cycle, RUN until the buffer fills, FULL until a pop.
  always_comb begin
    state_d = state_q;
    if (redirect) begin
      state_d = IF_RUN;
    end else begin
      case (state_q)
        IF_IDLE: state_d = IF_RUN;
        IF_RUN:  if (count_next == DEPTH_CNT) state_d = IF_FULL;
        IF_FULL: if (pop) state_d = IF_RUN;
        default: state_d = IF_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IF_IDLE;
    else      state_q <= state_d;
  end

  // Fetch address: redirects take the aligned target, otherwise step a word per fetch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= word_align(RESET_PC);
    end else if (redirect) begin
      pc_q <= word_align(redirect_target);
    end else if (fetch) begin
      pc_q <= pc_q + 32'd4;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fetch_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (fetch),
    .push_pc    (pc_q),
    .push_inst  (rom_inst_i),
    .pop        (pop),
    .clear      (redirect),
    .count      (fifo_count),
    .head_valid (id_valid_o),
    .head_pc    (id_pc_o),
    .head_inst  (id_inst_o)
  );

endmodule

// File: tb/tb_if_fetch_buf.sv
// Directed bench for if_fetch_buf with a queue-based scoreboard of fetched entries.
module tb_if_fetch_buf;

  localparam logic [31:0] K      = 32'hA5A5_0000;
  localparam int          DEPTH  = 2;
  localparam int          M_IDLE = 0;
  localparam int          M_RUN  = 1;
  localparam int          M_FULL = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        branch_flag = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        flush = 1'b0;
  logic [31:0] new_pc = 32'h0;
  logic        id_valid;
  logic        id_ready = 1'b1;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  logic        w_ce;
  logic [31:0] w_addr;
  logic [31:0] w_inst;
  logic        w_valid;
  logic [31:0] w_pc;
  logic [31:0] w_id_inst;

  int          checks = 0;
  int          errors = 0;
  int          m_state;
  logic [31:0] m_pc;
  logic [63:0] sb[$];

  // Free-running clock.
  always #5 clk = ~clk;

  // ROM models: the word returned is the address xor a fixed pattern.
  assign rom_inst = rom_addr ^ K;
  assign w_inst   = w_addr ^ K;

  if_fetch_buf dut (
    .clk             (clk),
    .rst             (rst),
    .rom_ce_o        (rom_ce),
    .rom_addr_o      (rom_addr),
    .rom_inst_i      (rom_inst),
    .branch_flag_i   (branch_flag),
    .branch_target_i (branch_target),
    .flush_i         (flush),
    .new_pc_i        (new_pc),
    .id_valid_o      (id_valid),
    .id_ready_i      (id_ready),
    .id_pc_o         (id_pc),
    .id_inst_o       (id_inst)
  );

  if_fetch_buf #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk             (clk),
    .rst             (rst),
    .rom_ce_o        (w_ce),
    .rom_addr_o      (w_addr),
    .rom_inst_i      (w_inst),
    .branch_flag_i   (1'b0),
    .branch_target_i (32'h0),
    .flush_i         (1'b0),
    .new_pc_i        (32'h0),
    .id_valid_o      (w_valid),
    .id_ready_i      (1'b1),
    .id_pc_o         (w_pc),
    .id_inst_o       (w_id_inst)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic model_ce();
    return (m_state == M_RUN) && (sb.size() < DEPTH);
  endfunction

  task automatic model_reset();
    m_state = M_IDLE;
    m_pc    = 32'h0;
    sb.delete();
  endtask

  task automatic model_edge();
    logic        ce;
    logic        pop;
    logic [31:0] tgt;
    ce  = model_ce();
    pop = (sb.size() != 0) && id_ready;
    if (flush || branch_flag) begin
      tgt = flush ? new_pc : branch_target;
      sb.delete();
      m_pc    = {tgt[31:2], 2'b00};
      m_state = M_RUN;
    end else begin
      if (pop) sb.delete(0);
      if (ce) begin
        sb.push_back({m_pc, m_pc ^ K});
        m_pc = m_pc + 32'd4;
      end
      case (m_state)
        M_IDLE:  m_state = M_RUN;
        M_RUN:   if (sb.size() == DEPTH) m_state = M_FULL;
        M_FULL:  if (pop) m_state = M_RUN;
        default: m_state = M_IDLE;
      endcase
    end
  endtask

  task automatic check_output();
    logic [63:0] head;
    head = (sb.size() != 0) ? sb[0] : 64'h0;
    check("rom_ce", {31'h0, rom_ce}, {31'h0, model_ce()});
    check("rom_addr", rom_addr, m_pc);
    check("id_valid", {31'h0, id_valid}, {31'h0, sb.size() != 0});
    check("id_pc", id_pc, head[63:32]);
    check("id_inst", id_inst, head[31:0]);
  endtask

  task automatic apply_stimulus(input logic ready, input logic br, input logic [31:0] tgt,
                                input logic fl, input logic [31:0] npc);
    id_ready      = ready;
    branch_flag   = br;
    branch_target = tgt;
    flush         = fl;
    new_pc        = npc;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_edge();
    @(negedge clk);
    check_output();
  endtask

  // Directed sequence: streaming, backpressure, branch, flush, async reset, IDLE redirect.
  initial begin
    model_reset();
    apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    check("rst_ce", {31'h0, rom_ce}, 32'h0);
    check("rst_addr", rom_addr, 32'h0);
    check("rst_valid", {31'h0, id_valid}, 32'h0);
    check("rst_pc", id_pc, 32'h0);
    check("rst_inst", id_inst, 32'h0);
    check("wrap_rst_addr", w_addr, 32'hFFFF_FFF8);

    // Streaming with ready held high.
    rst = 1'b1;
    check_output();
    check("t1_c0_ce", {31'h0, rom_ce}, 32'h0);
    check("wrap_c0_ce", {31'h0, w_ce}, 32'h0);
    cycle();
    check("t1_c1_addr", rom_addr, 32'h0);
    check("t1_c1_ce", {31'h0, rom_ce}, 32'h1);
    check("wrap_c1_addr", w_addr, 32'hFFFF_FFF8);
    check("wrap_c1_ce", {31'h0, w_ce}, 32'h1);
    cycle();
    check("t1_c2_valid", {31'h0, id_valid}, 32'h1);
    check("t1_c2_pc", id_pc, 32'h0);
    check("t1_c2_inst", id_inst, 32'hA5A5_0000);
    check("wrap_c2_addr", w_addr, 32'hFFFF_FFFC);
    check("wrap_c2_pc", w_pc, 32'hFFFF_FFF8);
    check("wrap_c2_inst", w_id_inst, 32'h5A5A_FFF8);
    cycle();
    check("t1_c3_pc", id_pc, 32'h4);
    check("wrap_c3_addr", w_addr, 32'h0);
    check("wrap_c3_pc", w_pc, 32'hFFFF_FFFC);
    cycle();
    check("t1_c4_pc", id_pc, 32'h8);
    check("wrap_c4_pc", w_pc, 32'h0);
    check("wrap_c4_inst", w_id_inst, 32'hA5A5_0000);
    cycle();
    check("t1_c5_pc", id_pc, 32'hC);

    // Backpressure from reset: fill, stall, single pop.
    rst = 1'b0;
    model_reset();
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    check_output();
    cycle();
    cycle();
    cycle();
    check("t2_full_ce", {31'h0, rom_ce}, 32'h0);
    check("t2_full_pc", id_pc, 32'h0);
    check("t2_full_addr", rom_addr, 32'h8);
    cycle();
    check("t2_hold_pc", id_pc, 32'h0);
    apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    cycle();
    check("t2_pop_pc", id_pc, 32'h4);
    check("t2_pop_ce", {31'h0, rom_ce}, 32'h1);
    check("t2_pop_addr", rom_addr, 32'h8);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cycle();
    check("t2_refill_ce", {31'h0, rom_ce}, 32'h0);

    // Branch with two entries buffered.
    apply_stimulus(1'b0, 1'b1, 32'h0000_0102, 1'b0, 32'h0);
    cycle();
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("t3_valid", {31'h0, id_valid}, 32'h0);
    check("t3_addr", rom_addr, 32'h100);
    cycle();
    check("t3_pc", id_pc, 32'h100);
    check("t3_inst", id_inst, 32'hA5A5_0100);

    // Flush and branch together; flush target wins.
    cycle();
    apply_stimulus(1'b1, 1'b1, 32'h100, 1'b1, 32'h20);
    cycle();
    apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    check("t4_addr", rom_addr, 32'h20);
    check("t4_valid", {31'h0, id_valid}, 32'h0);
    cycle();
    check("t4_pc", id_pc, 32'h20);
    cycle();
    check("t4_pc_next", id_pc, 32'h24);

    // Asynchronous reset mid-cycle with one entry buffered.
    #2 rst = 1'b0;
    #1;
    check("t5_ce", {31'h0, rom_ce}, 32'h0);
    check("t5_addr", rom_addr, 32'h0);
    check("t5_valid", {31'h0, id_valid}, 32'h0);
    check("t5_pc", id_pc, 32'h0);
    check("t5_inst", id_inst, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    check_output();
    check("t5_dead_ce", {31'h0, rom_ce}, 32'h0);
    cycle();
    check("t5_restart_addr", rom_addr, 32'h0);
    cycle();
    check("t5_restart_pc", id_pc, 32'h0);
    cycle();

    // Redirect during the IDLE cycle.
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    apply_stimulus(1'b1, 1'b1, 32'h40, 1'b0, 32'h0);
    check_output();
    cycle();
    apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    check("t6_addr", rom_addr, 32'h40);
    check("t6_ce", {31'h0, rom_ce}, 32'h1);
    cycle();
    check("t6_pc", id_pc, 32'h40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
